// File: rtl/key_cmd_if.sv
// Bundles the key-event inputs and the command handshake of key_cmd_scheduler.
// Handshake: a command transfers on any rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_code is stable and meaningful whenever cmd_valid
// is 1. cmd_valid never waits on cmd_ready.
interface key_cmd_if;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         cmd_ready;
    logic         cmd_valid;
    logic [2:0]   cmd_code;
    logic [4:0]   fifo_count;
    logic         merged;
    // Observation-only: per-arrow FSM states {RIGHT, LEFT, DOWN, UP}, 2 bits each.
    logic [7:0]   dbg_state;
    logic [2:0]   dbg_rr_ptr;
    logic [4:0]   dbg_pending;

    // The side that produces key events and consumes commands.
    modport master (
        output key_valid, last_change, key_down, cmd_ready,
        input  cmd_valid, cmd_code, fifo_count, merged,
        input  dbg_state, dbg_rr_ptr, dbg_pending
    );

    // The scheduler.
    modport slave (
        input  key_valid, last_change, key_down, cmd_ready,
        output cmd_valid, cmd_code, fifo_count, merged,
        output dbg_state, dbg_rr_ptr, dbg_pending
    );
endinterface

// File: rtl/key_cmd_scheduler.sv
// Turns PS/2 make codes for UP/DOWN/LEFT/RIGHT/Z into game commands.
// Arrow keys auto-repeat while held; concurrent events are merged into
// per-key pending bits, arbitrated round-robin into a small FWFT FIFO.
module key_cmd_scheduler #(
    parameter int DELAY_CYC  = 25_000_000,
    parameter int PERIOD_CYC = 10_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    key_cmd_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int CNT_MAX = (DELAY_CYC > PERIOD_CYC) ? DELAY_CYC : PERIOD_CYC;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] DELAY_LD  = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0] PERIOD_LD = CW'(PERIOD_CYC - 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    // Key index k occupies CODES[k*9 +: 9]: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 Z.
    localparam logic [44:0] CODES = {9'h01A, 9'h174, 9'h16B, 9'h172, 9'h175};

    logic [1:0]    st_q  [4];
    logic [1:0]    st_d  [4];
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic [4:0]    press;
    logic [3:0]    held;
    logic [4:0]    set_req;
    logic [4:0]    pend_q, pend_d;
    logic          merged_q, merged_d;
    logic [2:0]    rr_q, rr_d;

    logic          grant_vld;
    logic [2:0]    grant_idx;
    logic [4:0]    grant_mask;
    logic [2:0]    cand;
    logic [3:0]    cand_sum;

    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    fcnt_q, fcnt_d;
    logic          fifo_valid, pop, push, push_ok;

    logic          key_hit;
    assign key_hit = bus.key_down[bus.last_change];

    // Decode make events for the watched keys and sample their held state.
    always_comb begin
        press = '0;
        held  = '0;
        for (int k = 0; k < 5; k++) begin
            press[k] = bus.key_valid & key_hit & (bus.last_change == CODES[k*9 +: 9]);
        end
        for (int k = 0; k < 4; k++) begin
            held[k] = bus.key_down[CODES[k*9 +: 9]];
        end
    end

    // Typematic FSM per arrow key; a fresh press always restarts the delay,
    // and release is checked before expiry so a released key never repeats.
    always_comb begin
        set_req = '0;
        for (int k = 0; k < 4; k++) begin
            st_d[k]  = st_q[k];
            cnt_d[k] = cnt_q[k];
            if (press[k]) begin
                st_d[k]    = ST_DELAY;
                cnt_d[k]   = DELAY_LD;
                set_req[k] = 1'b1;
            end else begin
                case (st_q[k])
                    ST_DELAY, ST_REPEAT: begin
                        if (!held[k]) begin
                            st_d[k] = ST_IDLE;
                        end else if (cnt_q[k] == '0) begin
                            st_d[k]    = ST_REPEAT;
                            cnt_d[k]   = PERIOD_LD;
                            set_req[k] = 1'b1;
                        end else begin
                            cnt_d[k] = cnt_q[k] - CW'(1);
                        end
                    end
                    ST_IDLE: ;
                    default: st_d[k] = ST_IDLE;
                endcase
            end
        end
        set_req[4] = press[4];
    end

    assign fifo_valid = (fcnt_q != 5'd0);
    assign pop        = fifo_valid & bus.cmd_ready;
    assign push_ok    = (fcnt_q < 5'(FIFO_DEPTH)) | pop;

    // Round-robin search over pending keys starting at rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        cand      = 3'd0;
        cand_sum  = 4'd0;
        for (int i = 0; i < 5; i++) begin
            cand_sum = {1'b0, rr_q} + 4'(i);
            cand     = (cand_sum >= 4'd5) ? 3'(cand_sum - 4'd5) : cand_sum[2:0];
            if (!grant_vld && pend_q[cand] && push_ok) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign push       = grant_vld;
    assign grant_mask = grant_vld ? (5'b00001 << grant_idx) : 5'b00000;

    // Pending bits: grant clears, event sets; a set that lands on a bit that
    // stays pending counts as a merge.
    always_comb begin
        pend_d   = (pend_q & ~grant_mask) | set_req;
        merged_d = merged_q | (|(set_req & pend_q & ~grant_mask));
        rr_d     = rr_q;
        if (grant_vld) begin
            rr_d = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    // FIFO occupancy: push and pop together leave the count unchanged.
    always_comb begin
        fcnt_d = fcnt_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 5'd1;
            2'b01:   fcnt_d = fcnt_q - 5'd1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    // All state registers; reset discards everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                st_q[k]  <= ST_IDLE;
                cnt_q[k] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
            pend_q   <= '0;
            merged_q <= 1'b0;
            rr_q     <= 3'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= 5'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                st_q[k]  <= st_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            pend_q   <= pend_d;
            merged_q <= merged_d;
            rr_q     <= rr_d;
            fcnt_q   <= fcnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign bus.cmd_valid   = fifo_valid;
    assign bus.cmd_code    = fifo_valid ? mem_q[rd_ptr_q] : 3'd0;
    assign bus.fifo_count  = fcnt_q;
    assign bus.merged      = merged_q;
    assign bus.dbg_state   = {st_q[3], st_q[2], st_q[1], st_q[0]};
    assign bus.dbg_rr_ptr  = rr_q;
    assign bus.dbg_pending = pend_q;
endmodule
